pipe_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage MIPS pipeline (PC, IF, ID, EX, MEM, WB).
- Merges stall requests from ID (load-use), EX (multi-cycle div/mult) and MEM (data SRAM not ready) into the shared `StallBus`.
- Sequences the iterative divider with a start/done handshake.
- Turns exception requests into a one-cycle pipeline flush with redirect PC, deferring the flush while MEM is stalled.

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl_divseq.sv | 76 +++++++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// stall bus type, per-stage stop flags, stall encodings, divider FSM codes
// and a saturating increment helper for the optional perf counters.
package pipe_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    // bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
    typedef logic [STALL_BUS_W-1:0] StallBus;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam StallBus STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
    // Freeze PC/IF/ID, bubble into EX
    localparam StallBus STALL_LOAD = {NoStop, NoStop, NoStop, Stop, Stop, Stop};
    // Freeze up to EX, bubble into MEM
    localparam StallBus STALL_DIV  = {NoStop, NoStop, Stop, Stop, Stop, Stop};
    // Freeze up to MEM, bubble into WB
    localparam StallBus STALL_MEM  = {NoStop, Stop, Stop, Stop, Stop, Stop};

    // Divider sequencer state codes
    localparam logic [0:0] DIV_IDLE = 1'b0;
    localparam logic [0:0] DIV_RUN  = 1'b1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_ctrl_divseq.sv
// Iterative divider sequencer: IDLE/DIV_RUN FSM with a latched early result.
// Handshake: div_start is a one-cycle launch pulse issued only from IDLE;
// div_done is a one-cycle result pulse that counts only while in DIV_RUN
// (never in the launch cycle); if MEM is stalled when it arrives it is
// remembered in done_seen and consumed on the first unstalled cycle.
// div_cancel is a one-cycle abort pulse issued when a flush hits DIV_RUN.
module pipe_ctrl_divseq
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ex_div_req,
    input  logic div_done,
    input  logic mem_stall,
    input  logic flush,
    output logic div_start,
    output logic div_cancel,
    output logic div_hold,
    output logic state_dbg
);

    logic [0:0] state, state_nxt;
    logic       done_seen, done_seen_nxt;

    // Next-state and launch/abort/hold decode
    always_comb begin
        state_nxt     = state;
        done_seen_nxt = done_seen;
        div_start     = 1'b0;
        div_cancel    = 1'b0;
        div_hold      = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (ex_div_req && !mem_stall && !flush) begin
                    div_start = 1'b1;
                    div_hold  = 1'b1;
                    state_nxt = DIV_RUN;
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    div_cancel    = 1'b1;
                    done_seen_nxt = 1'b0;
                    state_nxt     = DIV_IDLE;
                end else if (mem_stall) begin
                    // Divider keeps running; MEM stall dominates the bus
                    done_seen_nxt = done_seen | div_done;
                end else if (div_done || done_seen) begin
                    // EX advances at this edge
                    done_seen_nxt = 1'b0;
                    state_nxt     = DIV_IDLE;
                end else begin
                    div_hold = 1'b1;
                end
            end
            default: begin
                state_nxt     = DIV_IDLE;
                done_seen_nxt = 1'b0;
            end
        endcase
    end

    // State and latched-result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_IDLE;
            done_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_seen <= done_seen_nxt;
        end
    end

    assign state_dbg = state[0];

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Merges ID/EX/MEM stall requests into the stall bus (flush > MEM > DIV >
// LOAD > NONE), sequences the divider, and converts exceptions into a
// one-cycle flush with redirect PC, deferred while MEM is stalled.
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int PC_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_stallreq,
    input  logic              ex_div_req,
    input  logic              div_done,
    input  logic              mem_stallreq,
    input  logic              except_req,
    input  logic [PC_W-1:0]   except_pc,
    output logic [STALL_W-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic              div_start,
    output logic              div_cancel,
    output logic              dbg_div_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_load_cyc,
    output logic [31:0]       perf_div_cyc,
    output logic [31:0]       perf_mem_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    logic            id_q, ex_q, done_q, mem_q, exc_q;
    logic            ld_mask;
    logic            flush_pend;
    logic [PC_W-1:0] pc_pend;
    logic            flush_now;
    logic            div_hold;
    StallBus         stall_sel;

    // Requests are qualified by reset so every output is quiet while held in reset
    always_comb begin
        id_q   = id_stallreq  & rst;
        ex_q   = ex_div_req   & rst;
        done_q = div_done     & rst;
        mem_q  = mem_stallreq & rst;
        exc_q  = except_req   & rst;
    end

    // Flush fires on a fresh or pending exception once MEM is not stalled; latest PC wins
    always_comb begin
        flush_now = !mem_q && (exc_q || flush_pend);
        new_pc    = '0;
        if (flush_now) begin
            new_pc = exc_q ? except_pc : pc_pend;
        end
    end

    pipe_ctrl_divseq u_divseq (
        .clk        (clk),
        .rst        (rst),
        .ex_div_req (ex_q),
        .div_done   (done_q),
        .mem_stall  (mem_q),
        .flush      (flush_now),
        .div_start  (div_start),
        .div_cancel (div_cancel),
        .div_hold   (div_hold),
        .state_dbg  (dbg_div_state)
    );

    // Stall priority mux
    always_comb begin
        stall_sel = STALL_NONE;
        if (flush_now) begin
            stall_sel = STALL_NONE;
        end else if (mem_q) begin
            stall_sel = STALL_MEM;
        end else if (div_hold) begin
            stall_sel = STALL_DIV;
        end else if (id_q && !ld_mask) begin
            stall_sel = STALL_LOAD;
        end
    end

    assign stall = stall_sel;
    assign flush = flush_now;

    // Load-use mask (one bubble per load) and deferred-flush latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_mask    <= 1'b0;
            flush_pend <= 1'b0;
            pc_pend    <= '0;
        end else begin
            ld_mask <= (stall_sel == STALL_LOAD);
            if (exc_q && mem_q) begin
                flush_pend <= 1'b1;
                pc_pend    <= except_pc;
            end else if (flush_now) begin
                flush_pend <= 1'b0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating stall-cycle and flush-pulse counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_cyc  <= '0;
            perf_div_cyc   <= '0;
            perf_mem_cyc   <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_sel == STALL_LOAD) perf_load_cyc <= sat_inc(perf_load_cyc);
            if (stall_sel == STALL_DIV)  perf_div_cyc  <= sat_inc(perf_div_cyc);
            if (stall_sel == STALL_MEM)  perf_mem_cyc  <= sat_inc(perf_mem_cyc);
            if (flush_now)               perf_flush_cnt <= sat_inc(perf_flush_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with constant
// expectations plus a randomized run against a behavioural model.
module tb_pipe_ctrl;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_LOAD = 6'b000111;
    localparam logic [5:0] S_DIV  = 6'b001111;
    localparam logic [5:0] S_MEM  = 6'b011111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        id_stallreq = 1'b0;
    logic        ex_div_req = 1'b0;
    logic        div_done = 1'b0;
    logic        mem_stallreq = 1'b0;
    logic        except_req = 1'b0;
    logic [31:0] except_pc = '0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        div_start;
    logic        div_cancel;
    logic        dbg_div_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_load_cyc, perf_div_cyc, perf_mem_cyc, perf_flush_cnt;
`endif

    pipe_ctrl #(.STALL_W(6), .PC_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_stallreq   (id_stallreq),
        .ex_div_req    (ex_div_req),
        .div_done      (div_done),
        .mem_stallreq  (mem_stallreq),
        .except_req    (except_req),
        .except_pc     (except_pc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .div_start     (div_start),
        .div_cancel    (div_cancel),
        .dbg_div_state (dbg_div_state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_load_cyc (perf_load_cyc),
        .perf_div_cyc  (perf_div_cyc),
        .perf_mem_cyc  (perf_mem_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    // {stall, flush, div_start, div_cancel}
    logic [8:0] obs;
    assign obs = {stall, flush, div_start, div_cancel};

    int n_vec = 0;
    int n_err = 0;
    logic [40:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic id, input logic ex, input logic done,
                         input logic mem, input logic exc, input logic [31:0] pc);
        id_stallreq  = id;
        ex_div_req   = ex;
        div_done     = done;
        mem_stallreq = mem;
        except_req   = exc;
        except_pc    = pc;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();
        settle();
        n_vec++;
        if ({obs, new_pc, dbg_div_state} !== 42'd0) begin
            n_err++;
            $display("FAIL reset_idle: got obs=%b pc=%h st=%b exp all zero", obs, new_pc, dbg_div_state);
        end
        // Active requests must not leak through while in reset
        drive(1, 1, 1, 0, 1, 32'h1234_5678);
        #1;
        n_vec++;
        if ({obs, new_pc} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_quiet: got obs=%b pc=%h exp all zero", obs, new_pc);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        logic [5:0] exp_s [3];
        exp_s[0] = S_LOAD;
        exp_s[1] = S_NONE;
        exp_s[2] = S_LOAD;
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            settle();
            n_vec++;
            if (obs !== {exp_s[c], 3'b000}) begin
                n_err++;
                $display("FAIL load_use c%0d: got %b exp %b", c + 1, obs, {exp_s[c], 3'b000});
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_divide();
        drive(0, 1, 0, 0, 0, 0);
        settle();
        n_vec++;
        if (obs !== {S_DIV, 3'b010}) begin
            n_err++;
            $display("FAIL div_start: got %b exp %b", obs, {S_DIV, 3'b010});
        end
        for (int c = 1; c < 5; c++) begin
            tick();
            settle();
            n_vec++;
            if (obs !== {S_DIV, 3'b000}) begin
                n_err++;
                $display("FAIL div_run c%0d: got %b exp %b", c, obs, {S_DIV, 3'b000});
            end
        end
        tick();
        drive(0, 1, 1, 0, 0, 0);
        settle();
        n_vec++;
        if (obs !== {S_NONE, 3'b000}) begin
            n_err++;
            $display("FAIL div_done: got %b exp %b", obs, {S_NONE, 3'b000});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({obs, dbg_div_state} !== 10'd0) begin
            n_err++;
            $display("FAIL div_idle: got obs=%b st=%b exp zero", obs, dbg_div_state);
        end
        // Stray div_done while idle is ignored
        tick();
        drive(0, 0, 1, 0, 0, 0);
        settle();
        tick();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({obs, dbg_div_state} !== 10'd0) begin
            n_err++;
            $display("FAIL div_stray_done: got obs=%b st=%b exp zero", obs, dbg_div_state);
        end
        tick();
    endtask

    task automatic test_div_mem();
        drive(0, 1, 0, 0, 0, 0);
        settle();
        n_vec++;
        if (obs !== {S_DIV, 3'b010}) begin
            n_err++;
            $display("FAIL divmem_start: got %b exp %b", obs, {S_DIV, 3'b010});
        end
        for (int c = 2; c <= 8; c++) begin
            tick();
            drive(0, 1, (c == 5), 1, 0, 0);
            settle();
            n_vec++;
            if (obs !== {S_MEM, 3'b000}) begin
                n_err++;
                $display("FAIL divmem_stall c%0d: got %b exp %b", c, obs, {S_MEM, 3'b000});
            end
        end
        tick();
        drive(0, 1, 0, 0, 0, 0);
        settle();
        n_vec++;
        if (obs !== {S_NONE, 3'b000}) begin
            n_err++;
            $display("FAIL divmem_release: got %b exp %b", obs, {S_NONE, 3'b000});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({obs, dbg_div_state} !== 10'd0) begin
            n_err++;
            $display("FAIL divmem_idle: got obs=%b st=%b exp zero", obs, dbg_div_state);
        end
        tick();
    endtask

    task automatic test_deferred_flush();
        drive(0, 0, 0, 1, 1, 32'hBFC0_0380);
        for (int c = 1; c <= 3; c++) begin
            settle();
            n_vec++;
            if (obs !== {S_MEM, 3'b000}) begin
                n_err++;
                $display("FAIL dflush_hold c%0d: got %b exp %b", c, obs, {S_MEM, 3'b000});
            end
            tick();
            drive(0, 0, 0, (c < 3), 0, 0);
        end
        settle();
        n_vec++;
        if ({obs, new_pc} !== {S_NONE, 3'b100, 32'hBFC0_0380}) begin
            n_err++;
            $display("FAIL dflush_fire: got obs=%b pc=%h exp %b pc=bfc00380", obs, new_pc, {S_NONE, 3'b100});
        end
        tick();
        settle();
        n_vec++;
        if ({obs, new_pc} !== 41'd0) begin
            n_err++;
            $display("FAIL dflush_once: got obs=%b pc=%h exp zero", obs, new_pc);
        end
        // Latest exception wins while deferred
        tick();
        drive(0, 0, 0, 1, 1, 32'h1111_0000);
        tick();
        drive(0, 0, 0, 1, 1, 32'h2222_0000);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({flush, new_pc} !== {1'b1, 32'h2222_0000}) begin
            n_err++;
            $display("FAIL dflush_latest: got flush=%b pc=%h exp 1 pc=22220000", flush, new_pc);
        end
        // Immediate flush when MEM is free
        tick();
        drive(0, 0, 0, 0, 1, 32'h8000_0180);
        settle();
        n_vec++;
        if ({obs, new_pc} !== {S_NONE, 3'b100, 32'h8000_0180}) begin
            n_err++;
            $display("FAIL flush_now: got obs=%b pc=%h exp %b pc=80000180", obs, new_pc, {S_NONE, 3'b100});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_flush_div();
        drive(0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 1, 32'h8000_0180);
        settle();
        n_vec++;
        if ({obs, new_pc} !== {S_NONE, 3'b101, 32'h8000_0180}) begin
            n_err++;
            $display("FAIL flushdiv_cancel: got obs=%b pc=%h exp %b", obs, new_pc, {S_NONE, 3'b101});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        settle();
        n_vec++;
        if ({obs, dbg_div_state} !== 10'd0) begin
            n_err++;
            $display("FAIL flushdiv_idle: got obs=%b st=%b exp zero", obs, dbg_div_state);
        end
        // Flush beats a fresh divide request: no launch
        tick();
        drive(0, 1, 0, 0, 1, 32'h0000_0040);
        settle();
        n_vec++;
        if (obs !== {S_NONE, 3'b100}) begin
            n_err++;
            $display("FAIL flush_blocks_start: got %b exp %b", obs, {S_NONE, 3'b100});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(0, 1, 0, 0, 0, 0);
        tick();
        settle();
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if ({obs, new_pc, dbg_div_state} !== 42'd0) begin
            n_err++;
            $display("FAIL async_reset: got obs=%b pc=%h st=%b exp zero", obs, new_pc, dbg_div_state);
        end
        tick();
        rst = 1'b1;
        settle();
        n_vec++;
        if (obs !== {S_DIV, 3'b010}) begin
            n_err++;
            $display("FAIL reset_resume: got %b exp %b", obs, {S_DIV, 3'b010});
        end
        tick();
        drive(0, 1, 1, 0, 0, 0);
        settle();
        n_vec++;
        if (obs !== {S_NONE, 3'b000}) begin
            n_err++;
            $display("FAIL resume_min_latency: got %b exp %b", obs, {S_NONE, 3'b000});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // Randomized run against a behavioural model of the stall/flush rules
    task automatic test_random(input int n);
        bit          div_busy = 0, result_held = 0, bubble_given = 0, redirect_pend = 0;
        logic [31:0] redirect_pc = '0;
        logic [40:0] got, want;
        for (int i = 0; i < n; i++) begin
            bit id, ex, done, mem, exc, fl, launch, ready, cancel;
            logic [31:0] pc, exp_pc;
            logic [5:0]  exp_s;
            id   = ($urandom_range(0, 99) < 40);
            ex   = ($urandom_range(0, 99) < 35);
            done = ($urandom_range(0, 99) < 25);
            mem  = ($urandom_range(0, 99) < 25);
            exc  = ($urandom_range(0, 99) < 8);
            pc   = $urandom;
            drive(id, ex, done, mem, exc, pc);

            fl     = !mem && (exc || redirect_pend);
            exp_pc = !fl ? 32'd0 : (exc ? pc : redirect_pc);
            launch = !div_busy && ex && !mem && !fl;
            ready  = done || result_held;
            cancel = div_busy && fl;
            if (fl)                                    exp_s = S_NONE;
            else if (mem)                              exp_s = S_MEM;
            else if (launch || (div_busy && !ready))   exp_s = S_DIV;
            else if (id && !bubble_given)              exp_s = S_LOAD;
            else                                       exp_s = S_NONE;
            exp_q.push_back({exp_s, fl, launch, cancel, exp_pc});

            bubble_given = (exp_s == S_LOAD);
            if (div_busy) begin
                if (fl) begin
                    div_busy = 0; result_held = 0;
                end else if (mem) begin
                    result_held = result_held || done;
                end else if (ready) begin
                    div_busy = 0; result_held = 0;
                end
            end else if (launch) begin
                div_busy = 1;
            end
            if (exc && mem) begin
                redirect_pend = 1; redirect_pc = pc;
            end else if (fl) begin
                redirect_pend = 0;
            end

            settle();
            got  = {obs, new_pc};
            want = exp_q.pop_front();
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random c%0d: got obs=%b pc=%h exp obs=%b pc=%h",
                         i, got[40:32], got[31:0], want[40:32], want[31:0]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_divide();
        test_div_mem();
        test_deferred_flush();
        test_flush_div();
        test_async_reset();
        test_random(800);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
